// File: rtl/tm1638_pkg.sv
// Shared constants, encodings and command-selection helper for the TM1638 scan controller.
package tm1638_pkg;

    localparam logic [7:0] CMD_MODE_WR  = 8'h40;
    localparam logic [7:0] CMD_MODE_RD  = 8'h42;
    localparam logic [7:0] CMD_ADDR0    = 8'hC0;
    localparam logic [7:0] CMD_CTRL_ON  = 8'h88;
    localparam logic [7:0] CMD_CTRL_OFF = 8'h80;

    localparam int DISP_BYTES = 16;
    localparam int KEY_BYTES  = 4;

    typedef enum logic [1:0] {
        S_MODE = 2'd0,
        S_DISP = 2'd1,
        S_CTRL = 2'd2,
        S_KEYS = 2'd3
    } step_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_GAP    = 3'd4
    } state_e;

    typedef struct packed {
        logic [7:0] cmd;
        logic       r_nw;
        logic [4:0] cnt;
    } cmd_t;

    // Command byte, direction and data-byte count for one step of the frame.
    function automatic cmd_t cmd_for(input step_e step, input logic disp_on, input logic [2:0] bri);
        cmd_t c;
        c.cmd  = CMD_MODE_WR;
        c.r_nw = 1'b0;
        c.cnt  = 5'd0;
        case (step)
            S_MODE: begin
                c.cmd = CMD_MODE_WR;
            end
            S_DISP: begin
                c.cmd = CMD_ADDR0;
                c.cnt = 5'(DISP_BYTES);
            end
            S_CTRL: begin
                c.cmd = disp_on ? (CMD_CTRL_ON | {5'd0, bri}) : CMD_CTRL_OFF;
            end
            S_KEYS: begin
                c.cmd  = CMD_MODE_RD;
                c.r_nw = 1'b1;
                c.cnt  = 5'(KEY_BYTES);
            end
            default: begin
                c.cmd = CMD_MODE_WR;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tm1638_disp_ram.sv
// 16x8 display RAM: synchronous write, asynchronous read (a same-cycle read sees the old byte).
module tm1638_disp_ram
    import tm1638_pkg::*;
(
    input  logic       mclk,
    input  logic       we_i,
    input  logic [3:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [3:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [DISP_BYTES];

    // Host write port; contents are left to configuration-time initialisation.
    always_ff @(posedge mclk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tm1638_scan_controller.sv
// Frame sequencer for a TM1638: mode, display data, control and key-scan commands,
// handed to an external byte transceiver, with a refresh gap between frames.
module tm1638_scan_controller
    import tm1638_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100000
)
(
    input  logic        mclk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        ram_we_i,
    input  logic [3:0]  ram_waddr_i,
    input  logic [7:0]  ram_wdata_i,
    input  logic        display_on_i,
    input  logic [2:0]  brightness_i,
    output logic [31:0] keys_o,
    output logic        keys_valid_o,
    output logic        busy_o,
    output logic        com_start_o,
    input  logic        com_stop_i,
    output logic        r_nw_o,
    output logic [4:0]  data_cnt_o,
    input  logic        cmd_request_i,
    input  logic [4:0]  data_addr_i,
    output logic [7:0]  wdata_o,
    input  logic [7:0]  rdata_i,
    input  logic        rdata_valid_i
);

    localparam int GAP_W = $clog2(REFRESH_CYCLES + 1);

    state_e           state_q;
    step_e            step_q;
    logic [GAP_W-1:0] gap_q;
    logic [7:0]       cmd_q;
    logic             r_nw_q;
    logic [4:0]       data_cnt_q;
    logic             com_start_q;
    logic             busy_q;
    logic             keys_valid_q;
    logic [31:0]      keys_q;
    logic [31:0]      key_buf_q;
    logic             rdv_prev_q;

    step_e            issue_step_d;
    cmd_t             issue_cmd_d;
    logic             key_edge_d;
    logic [7:0]       ram_rdata_s;
    logic             unused_s;

    tm1638_disp_ram u_disp_ram (
        .mclk    (mclk),
        .we_i    (ram_we_i),
        .waddr_i (ram_waddr_i),
        .wdata_i (ram_wdata_i),
        .raddr_i (data_addr_i[3:0]),
        .rdata_o (ram_rdata_s)
    );

    assign unused_s = data_addr_i[4];

    // Next command to issue and key-byte capture strobe.
    always_comb begin
        issue_step_d = step_q;
        if (state_q == ST_SETTLE) begin
            issue_step_d = step_e'(step_q + 2'd1);
        end else begin
            issue_step_d = step_q;
        end
        issue_cmd_d = cmd_for(issue_step_d, display_on_i, brightness_i);
        key_edge_d  = rdata_valid_i && !rdv_prev_q && (step_q == S_KEYS) && busy_q;
    end

    // Frame FSM with all transceiver-facing and status outputs registered.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            step_q       <= S_MODE;
            gap_q        <= '0;
            cmd_q        <= 8'h00;
            r_nw_q       <= 1'b0;
            data_cnt_q   <= 5'd0;
            com_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            keys_q       <= 32'h0000_0000;
            key_buf_q    <= 32'h0000_0000;
            rdv_prev_q   <= 1'b0;
        end else begin
            com_start_q  <= 1'b0;
            keys_valid_q <= 1'b0;
            rdv_prev_q   <= rdata_valid_i;
            if (key_edge_d) begin
                key_buf_q[{data_addr_i[1:0], 3'b000} +: 8] <= rdata_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (enable_i && (gap_q == '0)) begin
                        state_q     <= ST_ISSUE;
                        step_q      <= issue_step_d;
                        cmd_q       <= issue_cmd_d.cmd;
                        r_nw_q      <= issue_cmd_d.r_nw;
                        data_cnt_q  <= issue_cmd_d.cnt;
                        com_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (com_stop_i) begin
                        state_q <= ST_SETTLE;
                        if (step_q == S_KEYS) begin
                            keys_q       <= key_buf_q;
                            keys_valid_q <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    // The transceiver must drop com_stop before the next command may start.
                    if (!com_stop_i) begin
                        if (step_q == S_KEYS) begin
                            state_q    <= ST_GAP;
                            step_q     <= S_MODE;
                            gap_q      <= GAP_W'(REFRESH_CYCLES);
                            busy_q     <= 1'b0;
                            r_nw_q     <= 1'b0;
                            data_cnt_q <= 5'd0;
                        end else begin
                            state_q     <= ST_ISSUE;
                            step_q      <= issue_step_d;
                            cmd_q       <= issue_cmd_d.cmd;
                            r_nw_q      <= issue_cmd_d.r_nw;
                            data_cnt_q  <= issue_cmd_d.cnt;
                            com_start_q <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // GAP spans REFRESH_CYCLES cycles; IDLE then takes one decision cycle.
                    if (gap_q > GAP_W'(1)) begin
                        gap_q <= gap_q - GAP_W'(1);
                    end else begin
                        gap_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Byte presented to the transceiver: command, display data, or zero during reads.
    always_comb begin
        wdata_o = 8'h00;
        if (cmd_request_i) begin
            wdata_o = cmd_q;
        end else if (!r_nw_q) begin
            wdata_o = ram_rdata_s;
        end else begin
            wdata_o = 8'h00;
        end
    end

    assign keys_o       = keys_q;
    assign keys_valid_o = keys_valid_q;
    assign busy_o       = busy_q;
    assign com_start_o  = com_start_q;
    assign r_nw_o       = r_nw_q;
    assign data_cnt_o   = data_cnt_q;

endmodule

// File: tb/tb_tm1638_scan_controller.sv
// Directed bench for tm1638_scan_controller with a small transceiver BFM.
module tb_tm1638_scan_controller;

    localparam int R = 8;

    logic        mclk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ram_we;
    logic [3:0]  ram_waddr;
    logic [7:0]  ram_wdata;
    logic        display_on;
    logic [2:0]  brightness;
    logic [31:0] keys;
    logic        keys_valid;
    logic        busy;
    logic        com_start;
    logic        com_stop;
    logic        r_nw;
    logic [4:0]  data_cnt;
    logic        cmd_request;
    logic [4:0]  data_addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rdata_valid;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] ram_model [16];
    logic [7:0] key_src   [4];

    always #5 mclk = ~mclk;

    tm1638_scan_controller #(.REFRESH_CYCLES(R)) dut (
        .mclk          (mclk),
        .rst           (rst),
        .enable_i      (enable),
        .ram_we_i      (ram_we),
        .ram_waddr_i   (ram_waddr),
        .ram_wdata_i   (ram_wdata),
        .display_on_i  (display_on),
        .brightness_i  (brightness),
        .keys_o        (keys),
        .keys_valid_o  (keys_valid),
        .busy_o        (busy),
        .com_start_o   (com_start),
        .com_stop_i    (com_stop),
        .r_nw_o        (r_nw),
        .data_cnt_o    (data_cnt),
        .cmd_request_i (cmd_request),
        .data_addr_i   (data_addr),
        .wdata_o       (wdata),
        .rdata_i       (rdata),
        .rdata_valid_i (rdata_valid)
    );

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // BFM for one command. act: 0 none, 1 change control settings after issue, 2 drop enable after issue.
    task automatic run_cmd(input string tag, input logic [7:0] exp_cmd, input logic exp_rnw,
                           input logic [4:0] exp_cnt, input int act);
        int n;
        n = 0;
        cmd_request = 1'b1;
        while (com_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, " start"}, 32'(com_start), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " cmd"}, 32'(wdata), 32'(exp_cmd));
        check({tag, " rnw"}, 32'(r_nw), 32'(exp_rnw));
        check({tag, " cnt"}, 32'(data_cnt), 32'(exp_cnt));
        if (act == 1) begin
            display_on = 1'b1;
            brightness = 3'd2;
        end
        if (act == 2) begin
            enable = 1'b0;
        end
        tick();
        check({tag, " start_once"}, 32'(com_start), 32'd0);
        cmd_request = 1'b0;
        if (!exp_rnw) begin
            for (int i = 0; i < int'(exp_cnt); i++) begin
                data_addr = 5'(i);
                tick();
                check({tag, " data"}, 32'(wdata), 32'(ram_model[i]));
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                data_addr   = 5'(i);
                rdata       = key_src[i];
                rdata_valid = 1'b1;
                tick();
                rdata_valid = 1'b0;
                tick();
            end
            check({tag, " rd_wdata"}, 32'(wdata), 32'd0);
        end
        cmd_request = 1'b1;
        tick();
        check({tag, " held"}, 32'(wdata), 32'(exp_cmd));
        com_stop = 1'b1;
        tick();
        check({tag, " kv"}, 32'(keys_valid), 32'(exp_rnw));
        if (exp_rnw) begin
            check({tag, " keys"}, keys, {key_src[3], key_src[2], key_src[1], key_src[0]});
        end
        tick();
        check({tag, " kv_off"}, 32'(keys_valid), 32'd0);
        check({tag, " no_start"}, 32'(com_start), 32'd0);
        com_stop  = 1'b0;
        rdata     = 8'h00;
        data_addr = 5'd0;
    endtask

    initial begin
        int n;
        int low_cnt;
        int starts;
        rst = 1'b1; enable = 1'b0; ram_we = 1'b0; ram_waddr = 4'd0; ram_wdata = 8'h00;
        display_on = 1'b1; brightness = 3'd5; com_stop = 1'b0; cmd_request = 1'b0;
        data_addr = 5'd0; rdata = 8'h00; rdata_valid = 1'b0;
        repeat (3) tick();
        check("rst com_start", 32'(com_start), 32'd0);
        check("rst r_nw", 32'(r_nw), 32'd0);
        check("rst data_cnt", 32'(data_cnt), 32'd0);
        check("rst keys", keys, 32'd0);
        check("rst keys_valid", 32'(keys_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            ram_we = 1'b1; ram_waddr = 4'(i); ram_wdata = 8'(i); ram_model[i] = 8'(i);
            tick();
        end
        ram_we = 1'b0;

        // Write/read collision at address 3 while idle.
        data_addr = 5'd3; ram_we = 1'b1; ram_waddr = 4'd3; ram_wdata = 8'hA3;
        #1;
        check("coll old", 32'(wdata), 32'h03);
        tick();
        ram_we = 1'b0;
        check("coll new", 32'(wdata), 32'hA3);
        ram_we = 1'b1; ram_wdata = 8'h03;
        tick();
        ram_we = 1'b0; data_addr = 5'd0;

        // Frame 1: display on, brightness 5.
        key_src[0] = 8'h11; key_src[1] = 8'h22; key_src[2] = 8'h33; key_src[3] = 8'h44;
        enable = 1'b1;
        run_cmd("f1_mode", 8'h40, 1'b0, 5'd0, 0);
        run_cmd("f1_disp", 8'hC0, 1'b0, 5'd16, 0);
        run_cmd("f1_ctrl", 8'h8D, 1'b0, 5'd0, 0);
        run_cmd("f1_keys", 8'h42, 1'b1, 5'd4, 0);
        display_on = 1'b0;

        n = 0; low_cnt = 0;
        while (com_start !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (com_start !== 1'b1 && busy === 1'b0) low_cnt++;
        end
        check("gap idle cycles", 32'(low_cnt), 32'(R + 1));

        // Frame 2: display off, control change after S_CTRL issue must not affect it.
        key_src[0] = 8'hA5; key_src[1] = 8'h5A; key_src[2] = 8'h01; key_src[3] = 8'hFE;
        run_cmd("f2_mode", 8'h40, 1'b0, 5'd0, 0);
        run_cmd("f2_disp", 8'hC0, 1'b0, 5'd16, 0);
        run_cmd("f2_ctrl", 8'h80, 1'b0, 5'd0, 1);
        run_cmd("f2_keys", 8'h42, 1'b1, 5'd4, 0);

        // Frame 3: new settings apply; enable dropped during S_DISP.
        key_src[0] = 8'h01; key_src[1] = 8'h02; key_src[2] = 8'h03; key_src[3] = 8'h04;
        run_cmd("f3_mode", 8'h40, 1'b0, 5'd0, 0);
        run_cmd("f3_disp", 8'hC0, 1'b0, 5'd16, 2);
        run_cmd("f3_ctrl", 8'h8A, 1'b0, 5'd0, 0);
        run_cmd("f3_keys", 8'h42, 1'b1, 5'd4, 0);

        starts = 0;
        for (int i = 0; i < 3 * R; i++) begin
            com_stop = (i == 12 || i == 13) ? 1'b1 : 1'b0;
            tick();
            if (com_start === 1'b1) starts++;
        end
        com_stop = 1'b0;
        check("stopped starts", 32'(starts), 32'd0);
        check("stopped busy", 32'(busy), 32'd0);
        check("stopped keys", keys, 32'h0403_0201);

        // Reset while waiting on the transceiver.
        enable = 1'b1;
        n = 0;
        while (com_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("f4 start", 32'(com_start), 32'd1);
        tick();
        check("f4 wait busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("wrst busy", 32'(busy), 32'd0);
        check("wrst com_start", 32'(com_start), 32'd0);
        check("wrst keys", keys, 32'd0);
        check("wrst keys_valid", 32'(keys_valid), 32'd0);
        check("wrst r_nw", 32'(r_nw), 32'd0);
        check("wrst data_cnt", 32'(data_cnt), 32'd0);
        rst = 1'b0;
        run_cmd("f5_mode", 8'h40, 1'b0, 5'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tm1638_scan_controller.md
TM1638_SCAN_CONTROLLER -- requirements
Module: tm1638_scan_controller

Interface
REQ-001 Parameter: REFRESH_CYCLES, default 100000, idle mclk cycles between frames (min 1).
REQ-002 mclk  in  1  system clock; all logic on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 enable  in  1  1 = run frames continuously; 0 = stop after current frame.
REQ-005 ram_we / ram_waddr / ram_wdata  in  1/4/8  host write port to 16-byte display RAM.
REQ-006 display_on / brightness  in  1/3  display control settings.
REQ-007 keys  out  32  last key scan; byte k = read byte k.
REQ-008 keys_valid  out  1  one-cycle pulse when keys is updated.
REQ-009 busy  out  1  high while a frame is in progress.
REQ-010 com_start  out  1  one-cycle command start to the transceiver.
REQ-011 com_stop  in  1  transceiver end-of-command indication.
REQ-012 r_nw / data_cnt  out  1/5  transfer direction and data-byte count of the current command.
REQ-013 cmd_request / data_addr  in  1/5  transceiver command-phase flag and data-byte index.
REQ-014 wdata  out  8  command or data byte for the transceiver.
REQ-015 rdata / rdata_valid  in  8/1  received byte and its valid level.

Function
REQ-016 One frame is four commands, in order:
- S_MODE: 0x40, r_nw=0, data_cnt=0
- S_DISP: 0xC0, r_nw=0, data_cnt=16
- S_CTRL: 0x88|brightness if display_on, else 0x80; r_nw=0, data_cnt=0
- S_KEYS: 0x42, r_nw=1, data_cnt=4
REQ-017 FSM states:
- IDLE -> ISSUE when enable=1 and the gap counter has expired.
- ISSUE: com_start=1 for exactly one cycle -> WAIT.
- WAIT: on com_stop=1 -> SETTLE.
- SETTLE: waits for com_stop=0, then goes to ISSUE for the next step, or to GAP after S_KEYS.
- GAP: loads the counter with REFRESH_CYCLES, counts down to 0 -> IDLE.
REQ-018 r_nw, data_cnt and the command byte are registered at ISSUE and held stable until SETTLE exits.
REQ-019 wdata is combinational:
- cmd_request=1: wdata = the latched command byte.
- cmd_request=0 and r_nw=0: wdata = ram[data_addr[3:0]].
- otherwise: wdata = 0x00.
REQ-020 brightness and display_on are sampled only at S_CTRL ISSUE; changes at other times do not affect the frame in progress.
REQ-021 Key capture: on each rising edge of rdata_valid during S_KEYS, store rdata into key_buf[data_addr[1:0]].
REQ-022 When S_KEYS com_stop is seen: keys <= key_buf, and keys_valid pulses for one cycle in the same cycle keys changes.
REQ-023 RAM write is synchronous and takes effect the next cycle.
REQ-024 RAM write colliding with a read of the same address in the same cycle: the read returns the old byte.
REQ-025 Frames are not tear-protected: writes during S_DISP may appear in the current frame.
REQ-026 busy=1 in ISSUE, WAIT and SETTLE; 0 in IDLE and GAP.
REQ-027 enable falling mid-frame: the frame completes including S_KEYS, then GAP -> IDLE, which is held.
REQ-028 enable rising in GAP: no effect until the gap expires.
REQ-029 rdata_valid edges outside S_KEYS are ignored.
REQ-030 com_stop outside WAIT is ignored.
REQ-031 At most one com_start is issued per command; no new com_start before com_stop has been seen high and then low.

Reset
REQ-032 Outputs at reset: com_start=0, r_nw=0, data_cnt=0, keys=0, keys_valid=0, busy=0.
REQ-033 Internal state at reset: FSM=IDLE, step=S_MODE, gap counter=0 (first frame may start immediately), key_buf=0.
REQ-034 Display RAM contents are not reset; they are initialised to 0x00 at configuration.
REQ-035 Reset mid-frame aborts immediately; the transceiver shares rst and returns to its ready state together with this block.

Structure
REQ-036 Shared package tm1638_pkg holds:
- command constants: CMD_MODE_WR=0x40, CMD_MODE_RD=0x42, CMD_ADDR0=0xC0, CMD_CTRL_ON=0x88, CMD_CTRL_OFF=0x80
- step and FSM state encodings
- frame byte counts: 16 display bytes, 4 key bytes
REQ-037 One sub-module, tm1638_disp_ram: 16x8, one synchronous write port, one asynchronous read port.

Verification
REQ-038 Frame sequence: enable=1 with a transceiver BFM -> com_start sequence 0x40/cnt0, 0xC0/cnt16, 0x88|brightness/cnt0, 0x42/cnt4, r_nw=1 only on the last, then REFRESH_CYCLES idle cycles.
REQ-039 Display data: RAM = 0x00..0x0F, data_addr swept 0..15 with cmd_request=0 -> wdata = 0x00..0x0F in order.
REQ-040 Key read: BFM returns 0x11,0x22,0x33,0x44 at data_addr 0..3 -> keys=0x44332211 and keys_valid a single pulse after S_KEYS com_stop.
REQ-041 Control byte: display_on=0 -> control byte 0x80; brightness=5 with display_on=1 -> 0x8D; brightness change after S_CTRL issue -> no effect until the next frame.
REQ-042 enable drop and reset:
- enable dropped during S_DISP -> frame completes, then busy=0 and no further com_start.
- rst during WAIT -> next cycle FSM=IDLE, com_start=0, keys unchanged from reset value 0.
